// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state encoding and round-robin pick for the 4:1 arbiter
package mux_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // First set request bit searching p, p+1, p+2, p+3 with 2-bit wrap.
    // Callers only use the result when at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_w.sv
// rtl/mux4_w.sv - combinational W-bit 4:1 select
// Ports: din  - four packed W-bit inputs, input k at din[k*W +: W]
//        sel  - encoded select
//        data - selected input
module mux4_w #(
    parameter int W = 8
) (
    input  logic [4*W-1:0] din,
    input  logic [1:0]     sel,
    output logic [W-1:0]   data
);

    always_comb begin
        data = din[sel*W +: W];
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter sequencing a shared 4:1 mux datapath
// Optional feature macro: MUX4_ARB_LOCK_EN (adds lock input suppressing the hold timeout)
// Ports: clk, rst_n (async active-low)
//        req   - level request per requester, held until served
//        lock  - (MUX4_ARB_LOCK_EN only) suppresses timeout release while busy
//        din   - packed inputs, requester k at din[k*W +: W]
//        gnt   - registered one-hot grant
//        sel   - registered encoded owner
//        busy  - high while a grant is active
//        dout  - selected din slice while busy, else 0
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
`ifdef MUX4_ARB_LOCK_EN
    input  logic              lock,
`endif
    input  logic [NREQ*W-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [W-1:0]      dout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit TIMEOUT_ON = (MAX_HOLD != 0);
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_e      state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            busy_q, busy_d;

    logic [1:0]      pick;
    logic            timeout_en;
    logic            timeout;
    logic [W-1:0]    mux_data;

`ifdef MUX4_ARB_LOCK_EN
    assign timeout_en = !lock;
`else
    assign timeout_en = 1'b1;
`endif

    assign pick = rr_pick(req, ptr_q);

    // Forced rotation only when the owner has used its full budget and
    // someone else is actually waiting; a sole requester keeps the grant.
    assign timeout = TIMEOUT_ON && (hold_cnt_q == HOLD_SAT)
                     && (|(req & ~gnt_q)) && timeout_en;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = NREQ'(1) << pick;
                    sel_d      = pick;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                if (!req[sel_q] || timeout) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                end else if (TIMEOUT_ON && hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                // Turnaround cycle: requests are deliberately not sampled here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

    mux4_w #(.W(W)) u_mux (
        .din  (din),
        .sel  (sel_q),
        .data (mux_data)
    );

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign dout = busy_q ? mux_data : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter with a behavioural model
module tb_mux4_rr_arbiter;

    localparam int W        = 8;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic         lock = 1'b0;
    logic [4*W-1:0] din = '0;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] dout;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: phase 0 = no owner, 1 = owned, 2 = turnaround
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_hold  = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
`ifdef MUX4_ARB_LOCK_EN
        .lock  (lock),
`endif
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .dout  (dout)
    );

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic lk);
        logic [3:0] others;
        bit found;
        bit lock_eff;
`ifdef MUX4_ARB_LOCK_EN
        lock_eff = lk;
`else
        lock_eff = 1'b0 & lk;
`endif
        case (m_phase)
            0: if (r != 0) begin
                found = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && r[(m_ptr + i) % 4]) begin
                        m_owner = (m_ptr + i) % 4;
                        found = 1;
                    end
                end
                m_phase = 1;
                m_hold  = 0;
            end
            1: begin
                others = r & ~(4'b0001 << m_owner);
                if (!r[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1
                                    && others != 0 && !lock_eff)) begin
                    m_phase = 2;
                    m_ptr   = (m_owner + 1) % 4;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    function automatic logic [3:0] exp_gnt();
        return (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    function automatic logic [W-1:0] exp_dout();
        return (m_phase == 1) ? din[m_owner*W +: W] : '0;
    endfunction

    // Advance one clock; model sees the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(req, lock);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        din = $urandom;
        tick();
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_cmp++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    endtask

    task automatic test_single();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b0100;
        tick();
        for (int i = 0; i < 20; i++) begin
            din = {$urandom};
            #1;
            n_cmp++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || dout !== din[23:16]) begin
                n_fail++;
                $display("FAIL single_hold cyc=%0d got gnt=%b sel=%0d dout=%h exp gnt=0100 sel=2 dout=%h",
                         i, gnt, sel, dout, din[23:16]);
            end
            tick();
        end
        req = 4'b0000;
        tick();
        n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_gap got gnt=%b busy=%b exp 0000/0", gnt, busy); end
        req = 4'b1111;
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle got=%b exp=0000", gnt); end
        tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL single_ptr3 got=%b exp=1000", gnt); end
    endtask

    task automatic test_all_requesting();
        int owners[$];
        int lens[$];
        int gaps[$];
        int run;
        int zrun;
        logic [3:0] prev;
        pulse_reset();
        req = 4'b1111;
        prev = 4'b0000;
        run = 0;
        zrun = 0;
        for (int i = 0; i < 50; i++) begin
            din = {$urandom};
            tick();
            n_cmp++;
            if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL all_model cyc=%0d got=%b exp=%b", i, gnt, exp_gnt()); end
            if (gnt != 0 && prev == 0) begin
                owners.push_back(int'(sel));
                if (owners.size() > 1) gaps.push_back(zrun);
                run = 1;
            end else if (gnt != 0) begin
                run++;
            end else if (prev != 0) begin
                lens.push_back(run);
                zrun = 1;
            end else begin
                zrun++;
            end
            prev = gnt;
        end
        n_cmp++;
        if (owners.size() < 5 || lens.size() < 4 || gaps.size() < 4) begin
            n_fail++;
            $display("FAIL all_count got owners=%0d runs=%0d exp >=5/>=4", owners.size(), lens.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (owners[k] != k % 4) begin n_fail++; $display("FAIL all_order idx=%0d got=%0d exp=%0d", k, owners[k], k % 4); end
            end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (lens[k] != 8 || gaps[k] != 2) begin
                    n_fail++;
                    $display("FAIL all_timing idx=%0d got len=%0d gap=%0d exp len=8 gap=2", k, lens[k], gaps[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        req = 4'b1000;
        tick();
        n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_own3 got=%b exp=1000", gnt); end
        req = 4'b0011;
        tick();
        tick();
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_next got=%b exp=0001", gnt); end
    endtask

    task automatic test_timeout();
        int held;
        bit done;
        pulse_reset();
        req = 4'b0010;
        tick();
        held = (gnt === 4'b0010) ? 1 : 0;
        tick(); if (gnt === 4'b0010) held++;
        tick(); if (gnt === 4'b0010) held++;
        req = 4'b0110;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (gnt === 4'b0010) held++;
            else done = 1;
        end
        n_cmp++; if (!done || held != 8) begin n_fail++; $display("FAIL timeout_len got=%0d done=%0d exp=8", held, done); end
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL timeout_idle got=%b exp=0000", gnt); end
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL timeout_next got=%b exp=0100", gnt); end
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        req = 4'b1000;
        din = {$urandom};
        tick();
        tick();
        n_cmp++; if (gnt !== 4'b1000 || dout !== din[31:24]) begin n_fail++; $display("FAIL midrst_pre got gnt=%b dout=%h exp 1000/%h", gnt, dout, din[31:24]); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (gnt !== 4'b0000 || dout !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async got gnt=%b dout=%h busy=%b exp 0", gnt, dout, busy); end
        req = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_after got=%b exp=0010", gnt); end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = {$urandom};
            tick();
            n_cmp++;
            if (gnt !== exp_gnt() || busy !== (m_phase == 1) || dout !== exp_dout()
                || (busy && sel !== 2'(m_owner))) begin
                n_fail++;
                $display("FAIL random cyc=%0d got gnt=%b busy=%b sel=%0d dout=%h exp gnt=%b dout=%h owner=%0d",
                         i, gnt, busy, sel, dout, exp_gnt(), exp_dout(), m_owner);
            end
            if ($countones(gnt) > 1 || gnt[sel] !== busy) begin
                n_fail++;
                $display("FAIL invariant cyc=%0d got gnt=%b sel=%0d busy=%b", i, gnt, sel, busy);
            end
        end
    endtask

`ifdef MUX4_ARB_LOCK_EN
    task automatic test_lock();
        int bad;
        pulse_reset();
        lock = 1'b1;
        req = 4'b0011;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt !== 4'b0001) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL lock_hold got bad=%0d exp=0", bad); end
        lock = 1'b0;
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL lock_release got=%b exp=0000", gnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap();
        test_timeout();
        test_mid_reset();
        test_random();
`ifdef MUX4_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexed datapath between four requesters.
- Drives the mux select from registered grant state, holds a grant while the owner keeps requesting, and forces rotation after a bounded hold time.
- Sits in front of the existing 4:1 mux datapath as its sequencing controller.

Parameters:
- W, 8, data width of each mux input and of dout
- MAX_HOLD, 8, max consecutive grant cycles before forced release when others are waiting; 0 disables the timeout

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester, level, held until served
- din  input  4*W  packed inputs; requester k occupies din[k*W +: W]
- gnt  output  4  one-hot grant, registered
- sel  output  2  encoded select of current owner, registered
- busy  output  1  high while any grant is active
- dout  output  W  din slice selected by sel when busy, else 0 (combinational from registered sel/busy)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: gnt=0, sel=0, busy=0, dout=0, state=IDLE, ptr=0, hold_cnt=0.
- States:
  - IDLE: no owner. If any req bit is set, go to BUSY next edge. Owner = first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Set gnt/sel/busy and clear hold_cnt.
  - BUSY: owner holds the grant; hold_cnt increments each cycle and saturates at MAX_HOLD-1. Release when either:
    - req[owner]==0, or
    - MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another req bit is set.
    - On release: go to GAP next edge, gnt=0, busy=0, ptr=owner+1 (mod 4, 2-bit wrap 3->0).
  - GAP: exactly one idle turnaround cycle, then IDLE. Requests are ignored during GAP.
- Latency: req set in IDLE at edge N gives gnt at edge N+1. Minimum owner-to-owner gap is 2 cycles (GAP, then IDLE arbitration).
- Sole requester at timeout: grant retained, hold_cnt stays saturated, no release.
- A requester that drops req while not granted is simply skipped; no request memory is kept.
- Simultaneous requests: pointer order decides the winner. Fairness: every persistent requester is served within 3 other grants.
- req changes during BUSY on non-owners do not affect gnt until release.
- rst_n asserted mid-grant: all outputs clear immediately (asynchronous), ptr returns to 0.
- Invariants: gnt is one-hot or zero; gnt[sel]==busy.
- hold_cnt width = max(1, $clog2(MAX_HOLD)).

Optional Feature:
- Macro MUX4_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While busy and lock==1, the timeout release is suppressed; release on req[owner]==0 is unaffected. lock is ignored when not busy.
- Undefined: no lock port; timeout always applies as above.

Decomposition:
- Shared package (mux_arb_pkg): state encoding constants IDLE=2'd0, BUSY=2'd1, GAP=2'd2; NREQ=4.
- One natural sub-module: mux4_w, a combinational W-bit 4:1 select (din, sel -> data), instantiated once. mux4_rr_arbiter gates its output to 0 when not busy.

Test Plan:
- Reset: hold rst_n=0, req=4'b1111 -> gnt=0, sel=0, busy=0, dout=0. Release reset; next edge gnt=4'b0001.
- Single requester: req=4'b0100 for 20 cycles with MAX_HOLD=8 -> gnt=4'b0100 continuously, sel=2, dout=din[23:16]. Drop req -> GAP cycle with gnt=0, then IDLE, ptr=3.
- All requesting continuously: req=4'b1111 -> grant order 0,1,2,3,0. Each holds 8 cycles with a 2-cycle gap between owners.
- Pointer wrap: owner 3 releases with req=4'b0011 -> ptr=0, next gnt=4'b0001.
- Timeout: owner 1 holds req, req[2] rises -> release after exactly 8 grant cycles, then gnt=4'b0100.
- Mid-grant reset: assert rst_n=0 while gnt=4'b1000 -> gnt=0, dout=0 without waiting for a clock edge. After reset release with req=4'b1010, gnt=4'b0010.
- MUX4_ARB_LOCK_EN build: lock=1, req=4'b0011, owner 0 -> no timeout release after 20 cycles. lock=0 -> release on the next cycle.
